ranperm_engine: RTL and testbench

RANPERM_ENGINE -- requirements
Module: ranperm_engine

---
 rtl/ranperm_engine.sv | 150 +++++++++++++++
 tb/tb_ranperm_engine.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ranperm_engine.sv
// ranperm_engine: in-place Fisher-Yates shuffle of 0..N-1 driven by a 32-bit LFSR, one swap per clock.
// Optional build macro RANPERM_SEED_EN adds a seed input that reloads the LFSR on every accepted start.
module ranperm_engine #(
    parameter int          N    = 100,
    parameter logic [31:0] SEED = 32'hABCD,
    localparam int         W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         chain,
    input  logic [W-1:0] rd_addr,
`ifdef RANPERM_SEED_EN
    input  logic [31:0]  seed,
`endif
    output logic [W-1:0] rd_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        SHUFFLE = 1'b1
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    state_t       state_r;
    state_t       state_s;
    logic         busy_r;
    logic         done_r;
    logic         accept_s;
    logic         last_s;
    logic [W-1:0] i_r;
    logic [W-1:0] j_s;
    logic [31:0]  lfsr_r;
    logic [31:0]  lfsr_load_s;
    logic [W-1:0] arr_r     [N];
    logic [W-1:0] arr_s     [N];
    logic [W-1:0] ident_s   [N];

    // Next-state decode: accept start only from IDLE, leave SHUFFLE after the i=1 swap.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = SHUFFLE;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            SHUFFLE: begin
                if (i_r == W'(1)) begin
                    state_s = IDLE;
                    last_s  = 1'b1;
                end else begin
                    state_s = SHUFFLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Swap partner: full-width remainder keeps the draw unbiased by truncation, result always <= i.
    always_comb begin
        j_s = W'(lfsr_r % (32'(i_r) + 32'd1));
    end

    // LFSR value loaded on an accepted start.
    always_comb begin
`ifdef RANPERM_SEED_EN
        if (seed == 32'd0) begin
            lfsr_load_s = 32'h0000_0001;
        end else begin
            lfsr_load_s = seed;
        end
`else
        lfsr_load_s = lfsr_r;
`endif
    end

    // Identity pattern used by reset and by unchained starts.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            ident_s[k] = W'(k);
        end
    end

    // Next array contents: identity load or a single swap of entries i and j.
    always_comb begin
        arr_s = arr_r;
        if (accept_s && !chain) begin
            arr_s = ident_s;
        end else if (state_r == SHUFFLE) begin
            arr_s[i_r] = arr_r[j_s];
            arr_s[j_s] = arr_r[i_r];
        end else begin
            arr_s = arr_r;
        end
    end

    // Control, LFSR and array state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            i_r     <= '0;
            lfsr_r  <= SEED;
            arr_r   <= ident_s;
        end else begin
            state_r <= state_s;
            arr_r   <= arr_s;
            if (accept_s) begin
                busy_r <= 1'b1;
                done_r <= 1'b0;
                i_r    <= W'(N - 1);
                lfsr_r <= lfsr_load_s;
            end else if (state_r == SHUFFLE) begin
                lfsr_r <= lfsr_step(lfsr_r);
                i_r    <= i_r - W'(1);
                if (last_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    // Readout port; addresses past the array read as zero.
    always_comb begin
        if (32'(rd_addr) < 32'(N)) begin
            rd_data = arr_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_ranperm_engine.sv
// Directed bench for ranperm_engine: four instances (N = 2, 8, 16, 100) with hand-computed permutations.
module tb_ranperm_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] reset_v;
    logic [3:0] start_v;
    logic [3:0] chain_v;
    logic [6:0] addr;
    logic [0:0] rd2;
    logic [2:0] rd8;
    logic [3:0] rd16;
    logic [6:0] rd100;
    logic       b2, b8, b16, b100;
    logic       d2, d8, d16, d100;
    logic [3:0] busy_v;
    logic [3:0] done_v;
`ifdef RANPERM_SEED_EN
    logic [31:0] seed_v [4];
`endif

    assign busy_v = {b100, b16, b8, b2};
    assign done_v = {d100, d16, d8, d2};

    ranperm_engine #(.N(2)) u2 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .chain(chain_v[0]), .rd_addr(addr[0:0]),
`ifdef RANPERM_SEED_EN
        .seed(seed_v[0]),
`endif
        .rd_data(rd2), .busy(b2), .done(d2));

    ranperm_engine #(.N(8)) u8 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .chain(chain_v[1]), .rd_addr(addr[2:0]),
`ifdef RANPERM_SEED_EN
        .seed(seed_v[1]),
`endif
        .rd_data(rd8), .busy(b8), .done(d8));

    ranperm_engine #(.N(16)) u16 (
        .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .chain(chain_v[2]), .rd_addr(addr[3:0]),
`ifdef RANPERM_SEED_EN
        .seed(seed_v[2]),
`endif
        .rd_data(rd16), .busy(b16), .done(d16));

    ranperm_engine #(.N(100)) u100 (
        .clk(clk), .reset(reset_v[3]), .start(start_v[3]), .chain(chain_v[3]), .rd_addr(addr[6:0]),
`ifdef RANPERM_SEED_EN
        .seed(seed_v[3]),
`endif
        .rd_data(rd100), .busy(b100), .done(d100));

    int          checks = 0;
    int          errors = 0;
    int          nn [4] = '{2, 8, 16, 100};
    int          m_arr [4][100];
    logic [31:0] m_lfsr [4];
    logic        bz_log [0:127];
    logic        dn_log [0:127];
    logic [31:0] got [100];
    int          r16 [16];

    // Reference shuffle, written from the algorithm description.
    function automatic void m_reset(input int s);
        for (int k = 0; k < nn[s]; k++) m_arr[s][k] = k;
        m_lfsr[s] = 32'hABCD;
    endfunction

    function automatic void m_run(input int s, input bit ch);
        int j;
        int t;
        if (!ch) for (int k = 0; k < nn[s]; k++) m_arr[s][k] = k;
`ifdef RANPERM_SEED_EN
        m_lfsr[s] = (seed_v[s] == 32'd0) ? 32'h1 : seed_v[s];
`endif
        for (int i = nn[s] - 1; i >= 1; i--) begin
            j = int'(m_lfsr[s] % 32'(i + 1));
            t = m_arr[s][i];
            m_arr[s][i] = m_arr[s][j];
            m_arr[s][j] = t;
            m_lfsr[s] = {m_lfsr[s][30:0], m_lfsr[s][31] ^ m_lfsr[s][21] ^ m_lfsr[s][1] ^ m_lfsr[s][0]};
        end
    endfunction

    function automatic logic [31:0] rd_of(input int s);
        case (s)
            0:       rd_of = 32'(rd2);
            1:       rd_of = 32'(rd8);
            2:       rd_of = 32'(rd16);
            default: rd_of = 32'(rd100);
        endcase
    endfunction

    // Start in cycle 0, then log busy/done for cycles 1..ncyc; optional extra starts and a reset.
    task automatic go(input int s, input bit ch, input int ncyc, input int ign_a, input int ign_b, input int rst_at);
        @(negedge clk);
        start_v[s] = 1'b1;
        chain_v[s] = ch;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_v[s] = (c == ign_a) || (c == ign_b);
            reset_v[s] = (c == rst_at);
            bz_log[c]  = busy_v[s];
            dn_log[c]  = done_v[s];
        end
        start_v[s] = 1'b0;
        reset_v[s] = 1'b0;
    endtask

    task automatic read_arr(input int s);
        for (int k = 0; k < nn[s]; k++) begin
            addr = 7'(k);
            #1;
            got[k] = rd_of(s);
        end
    endtask

    task automatic pulse_reset(input int s);
        @(negedge clk);
        reset_v[s] = 1'b1;
        @(negedge clk);
        reset_v[s] = 1'b0;
        m_reset(s);
    endtask

    task automatic test_reset;
        reset_v = 4'hF;
        start_v = 4'h0;
        chain_v = 4'h0;
        addr    = 7'd0;
`ifdef RANPERM_SEED_EN
        seed_v[0] = 32'h1;
        seed_v[1] = 32'hABCD;
        seed_v[2] = 32'hABCD;
        seed_v[3] = 32'hABCD;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_v = 4'h0;
        for (int s = 0; s < 4; s++) m_reset(s);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags inst %0d: busy=%b done=%b expected 0 0", s, busy_v[s], done_v[s]);
            end
        end
        read_arr(1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== 32'(k)) begin
                errors++;
                $display("FAIL reset_ident8[%0d]: got %0d expected %0d", k, got[k], k);
            end
        end
        addr = 7'd99;
        #1;
        checks++;
        if (rd100 !== 7'd99) begin
            errors++;
            $display("FAIL reset_ident100[99]: got %0d expected 99", rd100);
        end
        for (int a = 100; a < 128; a++) begin
            addr = 7'(a);
            #1;
            checks++;
            if (rd100 !== 7'd0) begin
                errors++;
                $display("FAIL out_of_range[%0d]: got %0d expected 0", a, rd100);
            end
        end
    endtask

    task automatic test_n2;
        int e [2];
        go(0, 1'b0, 2, 0, 0, 0);
        checks++;
        if (bz_log[1] !== 1'b1 || dn_log[1] !== 1'b0 || bz_log[2] !== 1'b0 || dn_log[2] !== 1'b1) begin
            errors++;
            $display("FAIL n2_timing: c1 busy/done=%b%b c2 busy/done=%b%b expected 10 01", bz_log[1], dn_log[1], bz_log[2], dn_log[2]);
        end
        read_arr(0);
        e = '{0, 1};
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got[k] !== 32'(e[k])) begin
                errors++;
                $display("FAIL n2_run1[%0d]: got %0d expected %0d", k, got[k], e[k]);
            end
        end
`ifdef RANPERM_SEED_EN
        seed_v[0] = 32'h2;
        e = '{1, 0};
`else
        e = '{0, 1};
`endif
        go(0, 1'b0, 2, 0, 0, 0);
        read_arr(0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got[k] !== 32'(e[k])) begin
                errors++;
                $display("FAIL n2_run2[%0d]: got %0d expected %0d", k, got[k], e[k]);
            end
        end
    endtask

    task automatic test_n8_runs;
        int  p1 [8];
        int  e [8];
        bit  same;
        p1 = '{2, 6, 7, 4, 3, 0, 1, 5};
        go(1, 1'b0, 8, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (bz_log[c] !== (c < 8) || dn_log[c] !== (c == 8)) begin
                errors++;
                $display("FAIL n8_timing cycle %0d: busy=%b done=%b", c, bz_log[c], dn_log[c]);
            end
        end
        read_arr(1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== 32'(p1[k])) begin
                errors++;
                $display("FAIL n8_run1[%0d]: got %0d expected %0d", k, got[k], p1[k]);
            end
        end
        m_run(1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (done_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL n8_done_hold: busy=%b done=%b expected 0 1", busy_v[1], done_v[1]);
        end
        go(1, 1'b0, 8, 0, 0, 0);
        checks++;
        if (bz_log[1] !== 1'b1 || dn_log[1] !== 1'b0) begin
            errors++;
            $display("FAIL n8_restart_on_done: busy=%b done=%b expected 1 0", bz_log[1], dn_log[1]);
        end
        read_arr(1);
`ifdef RANPERM_SEED_EN
        e = p1;
`else
        e = '{3, 0, 1, 7, 5, 4, 6, 2};
`endif
        same = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (got[k] !== 32'(p1[k])) same = 1'b0;
            checks++;
            if (got[k] !== 32'(e[k])) begin
                errors++;
                $display("FAIL n8_run2[%0d]: got %0d expected %0d", k, got[k], e[k]);
            end
        end
        m_run(1, 1'b0);
`ifndef RANPERM_SEED_EN
        checks++;
        if (same) begin
            errors++;
            $display("FAIL n8_runs_differ: second chain=0 run repeated the first");
        end
`endif
    endtask

    task automatic test_back_to_back;
        bit seen [8];
        bit perm_ok;
        go(1, 1'b1, 8, 0, 0, 0);
        checks++;
        if (bz_log[1] !== 1'b1 || dn_log[1] !== 1'b0 || dn_log[8] !== 1'b1) begin
            errors++;
            $display("FAIL chain_timing: c1 busy/done=%b%b c8 done=%b", bz_log[1], dn_log[1], dn_log[8]);
        end
        m_run(1, 1'b1);
        read_arr(1);
        perm_ok = 1'b1;
        for (int k = 0; k < 8; k++) seen[k] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (got[k] >= 32'd8 || seen[got[k][2:0]]) perm_ok = 1'b0;
            else seen[got[k][2:0]] = 1'b1;
            checks++;
            if (got[k] !== 32'(m_arr[1][k])) begin
                errors++;
                $display("FAIL chain_result[%0d]: got %0d expected %0d", k, got[k], m_arr[1][k]);
            end
        end
        checks++;
        if (!perm_ok) begin
            errors++;
            $display("FAIL chain_perm: result is not a permutation of 0..7");
        end
    endtask

    task automatic test_n100;
        bit seen [100];
        bit perm_ok;
        go(3, 1'b0, 100, 0, 0, 0);
        for (int c = 1; c <= 100; c++) begin
            checks++;
            if (bz_log[c] !== (c < 100) || dn_log[c] !== (c == 100)) begin
                errors++;
                $display("FAIL n100_timing cycle %0d: busy=%b done=%b", c, bz_log[c], dn_log[c]);
            end
        end
        m_run(3, 1'b0);
        read_arr(3);
        perm_ok = 1'b1;
        for (int k = 0; k < 100; k++) seen[k] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (got[k] >= 32'd100 || seen[got[k][6:0]]) perm_ok = 1'b0;
            else seen[got[k][6:0]] = 1'b1;
            checks++;
            if (got[k] !== 32'(m_arr[3][k])) begin
                errors++;
                $display("FAIL n100_result[%0d]: got %0d expected %0d", k, got[k], m_arr[3][k]);
            end
        end
        checks++;
        if (!perm_ok) begin
            errors++;
            $display("FAIL n100_perm: result is not a permutation of 0..99");
        end
        addr = 7'd100;
        #1;
        checks++;
        if (rd100 !== 7'd0) begin
            errors++;
            $display("FAIL n100_oor: got %0d expected 0", rd100);
        end
    endtask

    task automatic test_ignore_start;
        pulse_reset(2);
        go(2, 1'b0, 16, 3, 10, 0);
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (bz_log[c] !== (c < 16) || dn_log[c] !== (c == 16)) begin
                errors++;
                $display("FAIL ignore_timing cycle %0d: busy=%b done=%b", c, bz_log[c], dn_log[c]);
            end
        end
        m_run(2, 1'b0);
        for (int k = 0; k < 16; k++) r16[k] = m_arr[2][k];
        read_arr(2);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got[k] !== 32'(r16[k])) begin
                errors++;
                $display("FAIL ignore_result[%0d]: got %0d expected %0d", k, got[k], r16[k]);
            end
        end
    endtask

    task automatic test_reset_abort;
        pulse_reset(2);
        go(2, 1'b0, 6, 0, 0, 5);
        checks++;
        if (bz_log[5] !== 1'b1 || bz_log[6] !== 1'b0 || dn_log[6] !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: c5 busy=%b c6 busy=%b done=%b expected 1 0 0", bz_log[5], bz_log[6], dn_log[6]);
        end
        read_arr(2);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got[k] !== 32'(k)) begin
                errors++;
                $display("FAIL abort_ident[%0d]: got %0d expected %0d", k, got[k], k);
            end
        end
        go(2, 1'b0, 16, 0, 0, 0);
        checks++;
        if (dn_log[16] !== 1'b1 || bz_log[15] !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun_timing: c15 busy=%b c16 done=%b expected 1 1", bz_log[15], dn_log[16]);
        end
        read_arr(2);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (got[k] !== 32'(r16[k])) begin
                errors++;
                $display("FAIL abort_rerun[%0d]: got %0d expected %0d", k, got[k], r16[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_n2();
        test_n8_runs();
        test_back_to_back();
        test_n100();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
